// File: rtl/csla_bec_pipe.sv
// csla_bec_pipe: pipelined square-root carry-select add/sub with BEC groups.
// Define CSLA_OVF_EN to add the registered signed-overflow output ovf.
module csla_bec_pipe #(
  parameter int WIDTH = 32,
  parameter int PIPE  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef CSLA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int W = WIDTH / PIPE;

  // One slice: groups of 2,3,4,... bits; later groups pick
  // between a cin=0 sum and its excess-1 (BEC) version.
  function automatic logic [W:0] slice_add(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         ci
  );
    logic [W-1:0] sm, s0, s1;
    logic c, c0, c1, t;
    int lo, hi;
    sm = '0;
    s0 = '0;
    s1 = '0;
    c  = ci;
    lo = 0;
    hi = 2;
    for (int g = 0; g < W; g++) begin
      if (lo < W) begin
        if (hi > W) hi = W;
        if (g == 0) begin
          for (int i = 0; i < W; i++) begin
            if (i >= lo && i < hi) begin
              sm[i] = a[i] ^ b[i] ^ c;
              c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
            end
          end
        end else begin
          c0 = 1'b0;
          t  = 1'b1;
          for (int i = 0; i < W; i++) begin
            if (i >= lo && i < hi) begin
              s0[i] = a[i] ^ b[i] ^ c0;
              c0 = (a[i] & b[i]) | (c0 & (a[i] ^ b[i]));
            end
          end
          for (int i = 0; i < W; i++) begin
            if (i >= lo && i < hi) begin
              s1[i] = s0[i] ^ t;
              t = t & s0[i];
            end
          end
          c1 = c0 | t;
          for (int i = 0; i < W; i++) begin
            if (i >= lo && i < hi) sm[i] = c ? s1[i] : s0[i];
          end
          c = c ? c1 : c0;
        end
        lo = hi;
        hi = lo + g + 3;
      end
    end
    return {c, sm};
  endfunction

  logic             adv;
  logic [WIDTH-1:0] yp;
  logic             c0;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign yp       = sub ? ~y : y;
  assign c0       = sub | cin;

  for (genvar k = 0; k < PIPE; k++) begin : g_st
    logic [WIDTH-k*W-1:0] xi, yi;
    logic                 ci, vi;
    logic [W:0]           r;
    logic [(k+1)*W-1:0]   so;

    assign r = slice_add(xi[W-1:0], yi[W-1:0], ci);

    if (k == 0) begin : g_in
      assign xi = x;
      assign yi = yp;
      assign ci = c0;
      assign vi = in_valid;
      assign so = r[W-1:0];
    end else begin : g_in
      logic [k*W-1:0] si;

      // Stage valid bit: shifts on adv, cleared by reset.
      always_ff @(posedge clk) begin
        if (rst) vi <= 1'b0;
        else if (adv) vi <= g_st[k-1].vi;
      end

      // Remaining operand bits, slice carry and partial sum.
      always_ff @(posedge clk) begin
        if (adv) begin
          xi <= g_st[k-1].xi[WIDTH-(k-1)*W-1:W];
          yi <= g_st[k-1].yi[WIDTH-(k-1)*W-1:W];
          ci <= g_st[k-1].r[W];
          si <= g_st[k-1].so;
        end
      end

      assign so = {r[W-1:0], si};
    end
  end

  // Output register: final sum, carry and valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
    end else if (adv) begin
      out_valid <= g_st[PIPE-1].vi;
      s         <= g_st[PIPE-1].so;
      cout      <= g_st[PIPE-1].r[W];
    end
  end

`ifdef CSLA_OVF_EN
  logic xs, ys;
  assign xs = g_st[PIPE-1].xi[W-1];
  assign ys = g_st[PIPE-1].yi[W-1];

  // Signed overflow, registered alongside s.
  always_ff @(posedge clk) begin
    if (rst) ovf <= 1'b0;
    else if (adv) ovf <= (xs == ys) && (g_st[PIPE-1].r[W-1] != xs);
  end
`endif

endmodule
